// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through data cache, 16 lines x 4 words
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int TagWidth = ADDR_WIDTH - 8;
  // Clears the byte-select bits so captured addresses are word aligned.
  localparam logic [ADDR_WIDTH-1:0] WordMask = ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} stateT;

  stateT                 state;
  stateT                 nextState;
  logic [15:0]           validBits;
  logic [TagWidth-1:0]   tagArr  [16];
  logic [DATA_WIDTH-1:0] dataArr [16][4];
  logic [1:0]            cnt;
  logic [ADDR_WIDTH-1:0] capAddr;
  logic [DATA_WIDTH-1:0] capData;

  logic [3:0]            reqIdx;
  logic [1:0]            reqOff;
  logic [TagWidth-1:0]   reqTag;
  logic [3:0]            capIdx;
  logic                  hit;
  logic [DATA_WIDTH-1:0] hitWord;

  logic                  stallNext;
  logic [DATA_WIDTH-1:0] dataNext;
  logic                  memReqNext;
  logic                  memWeNext;
  logic [ADDR_WIDTH-1:0] memAddrNext;
  logic [DATA_WIDTH-1:0] memWdataNext;

  assign reqIdx  = addr_i[7:4];
  assign reqOff  = addr_i[3:2];
  assign reqTag  = addr_i[ADDR_WIDTH-1:8];
  assign capIdx  = capAddr[7:4];
  assign hit     = req_i & validBits[reqIdx] & (tagArr[reqIdx] == reqTag);
  assign hitWord = dataArr[reqIdx][reqOff];

  // State, valid bits, beat counter and captured request; async reset aborts any transaction.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      validBits <= '0;
      cnt       <= 2'd0;
      capAddr   <= '0;
      capData   <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (req_i) begin
            capAddr <= addr_i & WordMask;
            capData <= data_i;
            if (!wr_en_i && !hit) begin
              cnt               <= 2'd0;
              // The line is being overwritten, so it must not hit until the last beat lands.
              validBits[reqIdx] <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) validBits[capIdx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays: store-hit update in IDLE, refill beats in REFILL; no reset needed.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && req_i && wr_en_i && hit) begin
      dataArr[reqIdx][reqOff] <= data_i;
    end
    if (state == REFILL && mem_ack_i) begin
      dataArr[capIdx][cnt] <= mem_rdata_i;
      if (cnt == 2'd3) tagArr[capIdx] <= capAddr[ADDR_WIDTH-1:8];
    end
  end

  // Next-state and output decode.
  always_comb begin
    nextState    = state;
    stallNext    = 1'b0;
    dataNext     = '0;
    memReqNext   = 1'b0;
    memWeNext    = 1'b0;
    memAddrNext  = '0;
    memWdataNext = '0;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (wr_en_i) begin
            stallNext = 1'b1;
            nextState = WRITE;
          end else if (hit) begin
            dataNext = hitWord;
          end else begin
            stallNext = 1'b1;
            nextState = REFILL;
          end
        end
      end
      REFILL: begin
        stallNext   = 1'b1;
        memReqNext  = 1'b1;
        memAddrNext = {capAddr[ADDR_WIDTH-1:4], cnt, 2'b00};
        if (mem_ack_i && cnt == 2'd3) nextState = DONE;
      end
      WRITE: begin
        stallNext    = 1'b1;
        memReqNext   = 1'b1;
        memWeNext    = 1'b1;
        memAddrNext  = capAddr;
        memWdataNext = capData;
        if (mem_ack_i) nextState = DONE;
      end
      DONE: begin
        // One free cycle so the stalled load can pick up the freshly filled word.
        if (req_i && !wr_en_i && hit) dataNext = hitWord;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Core-facing outputs are forced low while reset is asserted, regardless of req_i.
  assign stall_o     = stallNext & rst_n_i;
  assign data_o      = rst_n_i ? dataNext : '0;
  assign mem_req_o   = memReqNext;
  assign mem_we_o    = memWeNext;
  assign mem_addr_o  = memAddrNext;
  assign mem_wdata_o = memWdataNext;

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - randomized self-checking bench for data_cache
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] data;
  logic [31:0] data_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  data_cache dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .wr_en_i(wr), .addr_i(addr),
    .data_i(data), .data_o(data_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  int total = 0;
  int bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: backing memory plus which tag each index holds.
  logic [31:0] memModel [logic [31:0]];
  bit          mValid [16];
  logic [23:0] mTag [16];

  function automatic logic [31:0] memRd(logic [31:0] a);
    if (memModel.exists(a)) return memModel[a];
    return a ^ 32'h5EED_0000;
  endfunction

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
  } beat_t;
  beat_t expQ[$];

  int slowMode = 0;
  int waitLeft = -1;
  int beatCycles = 0;
  int acks = 0;

  // Per-cycle compare of memory-side outputs against expected beats, then the memory responder.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack  = 1'b0;
      waitLeft = -1;
    end else begin
      if (mem_req_o) begin
        if (expQ.size() == 0) check("unexpected_mem_req", 1, 0);
        else begin
          check("mem_addr", mem_addr_o, expQ[0].addr);
          check("mem_we", mem_we_o, expQ[0].we);
          if (expQ[0].we) check("mem_wdata", mem_wdata_o, expQ[0].wdata);
        end
        check("stall_during_mem", stall_o, 1);
        check("data_during_mem", data_o, 0);
      end else begin
        check("mem_we_idle", mem_we_o, 0);
        check("mem_addr_idle", mem_addr_o, 0);
        check("mem_wdata_idle", mem_wdata_o, 0);
        if (!req) begin
          check("stall_noreq", stall_o, 0);
          check("data_noreq", data_o, 0);
        end
      end
      if (mem_req_o) begin
        if (waitLeft < 0) waitLeft = (slowMode == 2) ? 3 : (slowMode == 1) ? $urandom_range(0, 3) : 0;
        beatCycles++;
        if (waitLeft == 0) begin
          mem_ack = 1'b1;
          if (expQ.size() > 0) begin
            beat_t b;
            b = expQ.pop_front();
            if (b.we) memModel[b.addr] = b.wdata;
            else mem_rdata = memRd(b.addr);
          end
          acks++;
          waitLeft = -1;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          waitLeft--;
        end
      end else begin
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
        waitLeft  = -1;
      end
    end
  end

  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rd);
    logic [3:0]  idx;
    logic [31:0] wa;
    bit          hit;
    int          bc0;
    int          n;
    @(posedge clk); #1;
    req = 1'b1; wr = we; addr = a; data = d;
    idx = a[7:4];
    wa  = a & 32'hFFFF_FFFC;
    hit = mValid[idx] && (mTag[idx] == a[31:8]);
    stalls = 0; rd = 32'h0; bc0 = beatCycles;
    if (!we && hit) begin
      @(negedge clk);
      check("hit_stall", stall_o, 0);
      rd = data_o;
      check("hit_data", data_o, memRd(wa));
    end else begin
      if (we) expQ.push_back('{wa, 1'b1, d});
      else for (int k = 0; k < 4; k++) expQ.push_back('{{a[31:4], 2'(k), 2'b00}, 1'b0, 32'h0});
      @(negedge clk);
      n = 0;
      while (stall_o === 1'b1 && n < 400) begin
        stalls++; n++;
        @(negedge clk);
      end
      if (n >= 400) begin
        check("stall_timeout", 1, 0);
        expQ.delete();
      end
      check("done_mem_req", mem_req_o, 0);
      check("done_beats_left", expQ.size(), 0);
      check("stall_len", stalls, 1 + beatCycles - bc0);
      if (!we) begin
        mValid[idx] = 1'b1;
        mTag[idx]   = a[31:8];
        rd = data_o;
        check("done_data", data_o, memRd(wa));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    int a0;
    logic [31:0] rd;
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    rst_n = 1'b0; req = 1'b1; wr = 1'b0; addr = 32'h14; data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall_o, 0);
    check("rst_data", data_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b0;
    for (int k = 0; k < 4; k++) memModel[32'h10 + 4 * k] = 32'hA0 + k;

    // Directed scenarios with single-cycle ack.
    access(1'b0, 32'h14, 32'h0, s, rd);
    check("cold_load_stall", s, 5);  check("cold_load_data", rd, 32'hA1);
    access(1'b0, 32'h1C, 32'h0, s, rd);
    check("hit_load_stall", s, 0);   check("hit_load_data", rd, 32'hA3);
    access(1'b1, 32'h14, 32'hDEADBEEF, s, rd);
    check("store_hit_stall", s, 2);
    access(1'b0, 32'h14, 32'h0, s, rd);
    check("load_after_store_stall", s, 0); check("load_after_store_data", rd, 32'hDEADBEEF);
    access(1'b1, 32'h114, 32'h12345678, s, rd);
    check("store_miss_stall", s, 2);
    access(1'b0, 32'h14, 32'h0, s, rd);
    check("still_hit_stall", s, 0);  check("still_hit_data", rd, 32'hDEADBEEF);
    access(1'b0, 32'h114, 32'h0, s, rd);
    check("evict_stall", s, 5);      check("evict_data", rd, 32'h12345678);
    access(1'b0, 32'h14, 32'h0, s, rd);
    check("evicted_stall", s, 5);    check("evicted_data", rd, 32'hDEADBEEF);

    // Slow memory: every beat acknowledged on its fourth cycle.
    slowMode = 2;
    access(1'b0, 32'h208, 32'h0, s, rd);
    check("slow_refill_stall", s, 17); check("slow_refill_data", rd, 32'h5EED_0208);

    // Reset during beat 2 of a refill.
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b0; addr = 32'h304;
    for (int k = 0; k < 4; k++) expQ.push_back('{32'h300 + 4 * k, 1'b0, 32'h0});
    a0 = acks; n = 0;
    while (acks < a0 + 2 && n < 100) begin
      @(posedge clk); n++;
    end
    if (n >= 100) check("abort_wait_timeout", 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_req", mem_req_o, 0);
    check("abort_stall", stall_o, 0);
    check("abort_data", data_o, 0);
    expQ.delete();
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b0;
    access(1'b0, 32'h304, 32'h0, s, rd);
    check("after_abort_stall", s, 17); check("after_abort_data", rd, 32'h5EED_0304);

    // Randomized traffic over a small address pool to force conflicts and hits.
    slowMode = 1;
    for (int t = 0; t < 300; t++) begin
      logic [31:0] ra;
      bit rwe;
      ra  = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4)
          | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      rwe = ($urandom_range(0, 9) < 3);
      access(rwe, ra, $urandom, s, rd);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
      end
    end

    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
